// File: rtl/rst_release_seq_if.sv
// ----------------------------------------------------------------------------
// rst_release_seq_if
// Groups the reset sequencer's software handshake and reset outputs.
//   sw_rst_req_i   : software reset request (level)
//   rst_o          : per-domain active-high resets, bit 0 releases first
//   all_released_o : high once every rst_o bit is low
//   sw_rst_ack_o   : one-cycle pulse when a software sequence completes
// master: the consumer/requester side; slave: the sequencer itself.
// ----------------------------------------------------------------------------
interface rst_release_seq_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   sw_rst_req_i;
  logic [NUM_DOMAINS-1:0] rst_o;
  logic                   all_released_o;
  logic                   sw_rst_ack_o;

  modport master (
    output sw_rst_req_i,
    input  rst_o,
    input  all_released_o,
    input  sw_rst_ack_o
  );

  modport slave (
    input  sw_rst_req_i,
    output rst_o,
    output all_released_o,
    output sw_rst_ack_o
  );
endinterface

// File: rtl/rst_release_seq.sv
// ----------------------------------------------------------------------------
// rst_release_seq
// Reset sequencer: takes the raw async active-high system reset and produces
// NUM_DOMAINS reset lines that assert asynchronously and release synchronously
// one at a time (bit 0 first), GAP_CYCLES apart, after a HOLD_CYCLES hold.
// A software request re-runs the same release sequence without system reset.
//
// Ports:
//   clk : clock, all state on rising edge
//   rst : asynchronous active-high system reset
//   bus : rst_release_seq_if.slave (sw_rst_req_i, rst_o, all_released_o,
//         sw_rst_ack_o)
//
// Build option: define RST_SEQ_SW_RST_EN to include the software reset path
// (SWRST state, software flag, ack pulse). Without it the request input is
// ignored, the ack output is tied low and RUN is terminal until rst.
// ----------------------------------------------------------------------------
module rst_release_seq #(
  parameter int NUM_DOMAINS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst,
  rst_release_seq_if.slave bus
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(GAP_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_SWRST   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [HOLD_W-1:0]      hold_q, hold_d, hold_inc;
  logic [GAP_W-1:0]       gap_q, gap_d, gap_inc;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   all_rel_q, all_rel_d;
  logic                   rst_sync;

  // Deassert synchronizer: async-set by rst, shifts zeros in once rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];
  assign hold_inc = hold_q + HOLD_W'(1);
  assign gap_inc  = gap_q + GAP_W'(1);

`ifdef RST_SEQ_SW_RST_EN
  logic sw_flag_q, sw_flag_d;
  logic ack_q, ack_d;
`else
  logic unused_sw_req;
  assign unused_sw_req = bus.sw_rst_req_i;
`endif

  // State and output registers; rst_o comes straight from async-set flops so
  // assertion has no combinational path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_HOLD;
      hold_q    <= '0;
      gap_q     <= '0;
      idx_q     <= '0;
      rst_q     <= '1;
      all_rel_q <= 1'b0;
`ifdef RST_SEQ_SW_RST_EN
      sw_flag_q <= 1'b0;
      ack_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      rst_q     <= rst_d;
      all_rel_q <= all_rel_d;
`ifdef RST_SEQ_SW_RST_EN
      sw_flag_q <= sw_flag_d;
      ack_q     <= ack_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    rst_d     = rst_q;
    all_rel_d = all_rel_q;
`ifdef RST_SEQ_SW_RST_EN
    sw_flag_d = sw_flag_q;
    ack_d     = 1'b0;
`endif
    case (state_q)
      S_HOLD: begin
        if (!rst_sync) begin
          hold_d = hold_inc;
          if (hold_inc == HOLD_MAX) begin
            state_d = S_RELEASE;
            gap_d   = '0;
            idx_d   = '0;
          end
        end
      end
      S_RELEASE: begin
        gap_d = gap_inc;
        if (gap_inc == GAP_MAX) begin
          gap_d        = '0;
          rst_d[idx_q] = 1'b0;
          idx_d        = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d   = S_RUN;
            all_rel_d = 1'b1;
`ifdef RST_SEQ_SW_RST_EN
            // Only a software-started sequence acknowledges on completion.
            if (sw_flag_q) begin
              ack_d     = 1'b1;
              sw_flag_d = 1'b0;
            end
`endif
          end
        end
      end
      S_RUN: begin
`ifdef RST_SEQ_SW_RST_EN
        if (bus.sw_rst_req_i) begin
          rst_d     = '1;
          all_rel_d = 1'b0;
          hold_d    = '0;
          sw_flag_d = 1'b1;
          state_d   = S_SWRST;
        end
`endif
      end
      S_SWRST: begin
`ifdef RST_SEQ_SW_RST_EN
        // Saturating hold; leave only once the hold is met and the request
        // has been withdrawn, so a long request stretches the reset.
        if (hold_q != HOLD_MAX) hold_d = hold_inc;
        if ((hold_d == HOLD_MAX) && !bus.sw_rst_req_i) begin
          state_d = S_RELEASE;
          gap_d   = '0;
          idx_d   = '0;
        end
`else
        state_d = S_HOLD;
`endif
      end
      default: state_d = S_HOLD;
    endcase
  end

  assign bus.rst_o          = rst_q;
  assign bus.all_released_o = all_rel_q;
`ifdef RST_SEQ_SW_RST_EN
  assign bus.sw_rst_ack_o   = ack_q;
`else
  assign bus.sw_rst_ack_o   = 1'b0;
`endif

endmodule

// File: tb/tb_rst_release_seq.sv
// ----------------------------------------------------------------------------
// tb_rst_release_seq
// Directed bench for rst_release_seq with default parameters. Expected
// {rst_o, all_released_o, sw_rst_ack_o} per cycle are derived from the
// release-edge formulas, queued when the step is driven, and popped when the
// DUT output is sampled 1 time unit after the clock edge.
// ----------------------------------------------------------------------------
module tb_rst_release_seq;

  localparam int ND = 4;
  localparam int SS = 2;
  localparam int HC = 8;
  localparam int GC = 4;

  typedef struct packed {
    logic [ND-1:0] r;
    logic          a;
    logic          k;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   e = 0;
  exp_t sb[$];

  rst_release_seq_if #(.NUM_DOMAINS(ND)) bus ();

  rst_release_seq #(
    .NUM_DOMAINS(ND),
    .SYNC_STAGES(SS),
    .HOLD_CYCLES(HC),
    .GAP_CYCLES (GC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected outputs after edge ee of a sequence whose hold ends at edge m:
  // bit k falls at m+(k+1)*GC, all_released from the last fall, ack for the
  // cycle after the last fall when the sequence was software-started.
  function automatic exp_t expect_at(int ee, int m, bit sw);
    exp_t x;
    for (int k = 0; k < ND; k++) x.r[k] = (ee < m + GC * (k + 1));
    x.a = (ee >= m + GC * ND);
    x.k = sw && (ee == m + GC * ND);
    return x;
  endfunction

  function automatic exp_t in_reset();
    exp_t x;
    x.r = '1;
    x.a = 1'b0;
    x.k = 1'b0;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag);
    exp_t obs, req;
    obs = {bus.rst_o, bus.all_released_o, bus.sw_rst_ack_o};
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s: edge=%0d scoreboard empty, observed=%b", tag, e, obs);
    end else begin
      req = sb.pop_front();
      assert (obs === req) else begin
        miscompares++;
        $error("FAIL %s: edge=%0d observed rst_o/all/ack=%b expected=%b", tag, e, obs, req);
      end
    end
  endtask

  initial begin
    bus.sw_rst_req_i = 1'b0;
    rst = 1'b1;

    // Power-on reset held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      sb.push_back(in_reset());
      check("por_hold");
    end

    // Release; request pulses in RELEASE (edges 15..20) must be ignored.
    rst = 1'b0;
    e = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      e++;
      sb.push_back(expect_at(e, SS + HC, 1'b0));
      check("por_release");
      if (e == 14) bus.sw_rst_req_i = 1'b1;
      if (e == 20) bus.sw_rst_req_i = 1'b0;
    end

    // Asynchronous assertion mid-cycle after bits 0-1 have released.
    #3;
    rst = 1'b1;
    #1;
    sb.push_back(in_reset());
    check("async_assert");
    for (int i = 0; i < 3; i++) begin
      tick();
      sb.push_back(in_reset());
      check("async_hold");
    end

    // Restarted sequence from edge 1, then idle in RUN through edge 39.
    rst = 1'b0;
    e = 0;
    for (int i = 0; i < 39; i++) begin
      tick();
      e++;
      sb.push_back(expect_at(e, SS + HC, 1'b0));
      check("restart");
    end
    bus.sw_rst_req_i = 1'b1;

`ifdef RST_SEQ_SW_RST_EN
    // Single-cycle request sampled at edge 40; hold ends at 48.
    for (int i = 0; i < 39; i++) begin
      tick();
      e++;
      sb.push_back(expect_at(e, 40 + HC, 1'b1));
      check("sw_pulse");
      if (e == 40) bus.sw_rst_req_i = 1'b0;
      if (e == 79) bus.sw_rst_req_i = 1'b1;
    end
    // Long request held edges 80..99; SWRST exits at 100.
    for (int i = 0; i < 40; i++) begin
      tick();
      e++;
      sb.push_back(expect_at(e, 100, 1'b1));
      check("sw_long");
      if (e == 99) bus.sw_rst_req_i = 1'b0;
    end
`else
    // Without the software path a held request changes nothing.
    for (int i = 0; i < 30; i++) begin
      tick();
      e++;
      sb.push_back(expect_at(e, SS + HC, 1'b0));
      check("sw_disabled");
    end
    bus.sw_rst_req_i = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
